// File: rtl/wb_ctrl_pkg.sv
// Shared types for the button-driven Wishbone controller: FSM states, outcome codes and
// a small decode helper.
package wb_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    BACKOFF,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK,
    ST_ERR,
    ST_RTY,
    ST_TIMEOUT
  } status_t;

  // Retry counter width; it covers MAX_RETRIES up to 15.
  localparam int unsigned RetryW = 4;

  // cyc_o is high in exactly these states.
  function automatic logic on_bus(state_t s);
    return (s == REQ) || (s == WAIT);
  endfunction

endpackage

// File: rtl/wb_button_controller_if.sv
// Controller-side pipelined Wishbone signals. Names are taken from the controller's point of
// view; the master modport is the controller and the slave modport is the device.
interface wb_button_controller_if #(
  parameter int unsigned DAT_WIDTH = 8
) ();

  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [DAT_WIDTH-1:0] dat_o;
  logic [DAT_WIDTH-1:0] dat_i;
  logic                 ack_i;
  logic                 err_i;
  logic                 rty_i;
  logic                 stall_i;

  modport master (
    output cyc_o,
    output stb_o,
    output we_o,
    output dat_o,
    input  dat_i,
    input  ack_i,
    input  err_i,
    input  rty_i,
    input  stall_i
  );

  modport slave (
    input  cyc_o,
    input  stb_o,
    input  we_o,
    input  dat_o,
    output dat_i,
    output ack_i,
    output err_i,
    output rty_i,
    output stall_i
  );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and rising-edge pulse.
// press_o is a one-cycle pulse once the button has read high for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            press_q, press_d;

  // The counter tracks consecutive cycles on which the synchronised input disagrees with
  // the accepted level; any agreement restarts it, which is what rejects bounce.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d    = '0;
      stable_d = sync_q[1];
      press_d  = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/wb_button_controller.sv
// Button-driven single-beat pipelined Wishbone controller with retry and status capture.
// Define WB_CTRL_TIMEOUT_EN to add an abort after TIMEOUT_CYCLES cycles of cyc_o.
module wb_button_controller
  import wb_ctrl_pkg::*;
#(
  parameter int unsigned DAT_WIDTH       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   btn_wr_i,
  input  logic                   btn_rd_i,
  input  logic [DAT_WIDTH-1:0]   sw_dat_i,
  wb_button_controller_if.master wb,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [1:0]             status_o,
  output logic [DAT_WIDTH-1:0]   rd_dat_o
);

  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRIES);

  logic wr_press, rd_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbnc_wr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_wr_i),
    .press_o(wr_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbnc_rd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_rd_i),
    .press_o(rd_press)
  );

  state_t               state_q, state_d;
  logic [RetryW-1:0]    retry_q, retry_d;
  logic                 we_q, we_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  status_t              status_q, status_d;
  logic [DAT_WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic                 cyc_q, stb_q, busy_q, done_q;
  logic                 timeout_hit;
  logic                 term_valid;

`ifdef WB_CTRL_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES - 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Runs only while the bus is held, so BACKOFF, DONE and IDLE all restart it.
  always_comb begin
    to_cnt_d = '0;
    if (on_bus(state_q)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = on_bus(state_q) && (to_cnt_q == ToMax);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Terminations only count once the strobe has actually been accepted.
  assign term_valid = ((state_q == REQ) && !wb.stall_i) || (state_q == WAIT);

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    we_d     = we_q;
    dat_d    = dat_q;
    status_d = status_q;
    rd_dat_d = rd_dat_q;

    unique case (state_q)
      IDLE: begin
        if (wr_press || rd_press) begin
          we_d    = wr_press;
          state_d = REQ;
          if (wr_press) begin
            dat_d = sw_dat_i;
          end
        end
      end

      REQ, WAIT: begin
        if (term_valid && wb.err_i) begin
          status_d = ST_ERR;
          state_d  = DONE;
        end else if (term_valid && wb.rty_i) begin
          if (retry_q < MaxRetry) begin
            retry_d = retry_q + 1'b1;
            state_d = BACKOFF;
          end else begin
            status_d = ST_RTY;
            state_d  = DONE;
          end
        end else if (term_valid && wb.ack_i) begin
          status_d = ST_OK;
          state_d  = DONE;
          if (!we_q) begin
            rd_dat_d = wb.dat_i;
          end
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
          state_d  = DONE;
        end else if ((state_q == REQ) && !wb.stall_i) begin
          state_d = WAIT;
        end
      end

      BACKOFF: state_d = REQ;

      DONE: begin
        retry_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Bus and status outputs are flops fed from the next state, so they change on the same
  // edge as the state and reset clears them asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      retry_q  <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      status_q <= ST_OK;
      rd_dat_q <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      status_q <= status_d;
      rd_dat_q <= rd_dat_d;
      cyc_q    <= on_bus(state_d);
      stb_q    <= (state_d == REQ);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = stb_q;
  assign wb.we_o  = we_q;
  assign wb.dat_o = dat_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign status_o = status_q;
  assign rd_dat_o = rd_dat_q;

endmodule

// File: tb/tb_wb_button_controller.sv
// Scenario bench for wb_button_controller: expected outcomes are queued at each press and
// checked against status_o/rd_dat_o when done_o pulses.
module tb_wb_button_controller;
  import wb_ctrl_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_wr, btn_rd;
  logic [DW-1:0] sw;
  logic          busy, done;
  logic [1:0]    status;
  logic [DW-1:0] rd_dat;

  wb_button_controller_if #(.DAT_WIDTH(DW)) wb ();

  wb_button_controller #(
    .DAT_WIDTH      (DW),
    .DEBOUNCE_CYCLES(4),
    .MAX_RETRIES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_wr_i(btn_wr),
    .btn_rd_i(btn_rd),
    .sw_dat_i(sw),
    .wb      (wb),
    .busy_o  (busy),
    .done_o  (done),
    .status_o(status),
    .rd_dat_o(rd_dat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    status;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          exp;
  logic [DW-1:0] model_rd;
  int            total = 0;
  int            bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Holds the button(s) until cyc_o rises; on return the DUT is in its first REQ cycle.
  task automatic press(input logic wr, input logic rd, output bit ok);
    idle(10);
    btn_wr = wr;
    btn_rd = rd;
    ok     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wb.cyc_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    btn_wr = 1'b0;
    btn_rd = 1'b0;
  endtask

  // Device model from the first REQ cycle: stall, accept, then one termination cycle.
  // term: 0 ack, 1 err, 2 rty, 3 ack+err, 4 silent.
  task automatic serve(input int stalls, input int term, input logic [DW-1:0] rdat,
                       output int stbs);
    stbs       = 0;
    wb.stall_i = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      if (wb.stb_o === 1'b1) stbs++;
      tick();
    end
    wb.stall_i = 1'b0;
    if (wb.stb_o === 1'b1) stbs++;
    tick();
    wb.dat_i = rdat;
    wb.ack_i = (term == 0) || (term == 3);
    wb.err_i = (term == 1) || (term == 3);
    wb.rty_i = (term == 2);
    tick();
    wb.ack_i = 1'b0;
    wb.err_i = 1'b0;
    wb.rty_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_wr = 1'b0; btn_rd = 1'b0; sw = '0;
    wb.dat_i = '0; wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.rty_i = 1'b0; wb.stall_i = 1'b0;
    model_rd = '0;
    idle(2);
    total++;
    if ({wb.cyc_o, wb.stb_o, wb.we_o, wb.dat_o, busy, done, status, rd_dat} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {wb.cyc_o, wb.stb_o, wb.we_o, wb.dat_o, busy, done, status, rd_dat});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write_ack();
    bit ok;
    int n;
    sw = 8'hA5;
    sb_q.push_back('{status: ST_OK, rd: model_rd});
    press(1'b1, 1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wr_start: got cyc=0 want cyc=1"); end
    total++;
    if ({wb.stb_o, wb.we_o, wb.dat_o} !== {1'b1, 1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL wr_req: got stb/we/dat=%b/%b/%h want 1/1/a5", wb.stb_o, wb.we_o, wb.dat_o);
    end
    sw = 8'h00;
    serve(0, 0, 8'hEE, n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL wr_strobes: got %0d want 1", n); end
    total++;
    if ({done, wb.we_o, wb.dat_o} !== {1'b1, 1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL wr_done: got done/we/dat=%b/%b/%h want 1/1/a5", done, wb.we_o, wb.dat_o);
    end
    exp = sb_q.pop_front();
    total++;
    if ({status, rd_dat} !== {exp.status, exp.rd}) begin
      bad++;
      $display("FAIL wr_result: got %h/%h want %h/%h", status, rd_dat, exp.status, exp.rd);
    end
    tick();
    total++;
    if ({done, busy, wb.cyc_o} !== 3'b000) begin
      bad++;
      $display("FAIL wr_after: got done/busy/cyc=%b want 000", {done, busy, wb.cyc_o});
    end
  endtask

  task automatic test_read_stall();
    bit ok;
    int n;
    sb_q.push_back('{status: ST_OK, rd: 8'h3C});
    model_rd = 8'h3C;
    press(1'b0, 1'b1, ok);
    total++;
    if (!ok || wb.we_o !== 1'b0) begin
      bad++;
      $display("FAIL rd_start: got ok/we=%b/%b want 1/0", ok, wb.we_o);
    end
    serve(3, 0, 8'h3C, n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL rd_stall_strobes: got %0d want 4", n); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL rd_done: got %b want 1", done); end
    exp = sb_q.pop_front();
    total++;
    if ({status, rd_dat} !== {exp.status, exp.rd}) begin
      bad++;
      $display("FAIL rd_result: got %h/%h want %h/%h", status, rd_dat, exp.status, exp.rd);
    end
  endtask

  task automatic test_retry_exhaust();
    bit ok;
    int n, stbs;
    stbs = 0;
    sb_q.push_back('{status: ST_RTY, rd: model_rd});
    press(1'b0, 1'b1, ok);
    for (int a = 0; a < 3; a++) begin
      serve(0, 2, 8'h99, n);
      stbs += n;
      if (a < 2) begin
        total++;
        if ({wb.cyc_o, done} !== 2'b00) begin
          bad++;
          $display("FAIL rty_backoff%0d: got cyc/done=%b want 00", a, {wb.cyc_o, done});
        end
        tick();
        total++;
        if ({wb.cyc_o, wb.stb_o} !== 2'b11) begin
          bad++;
          $display("FAIL rty_reissue%0d: got cyc/stb=%b want 11", a, {wb.cyc_o, wb.stb_o});
        end
      end
    end
    total++;
    if (stbs !== 3 || done !== 1'b1) begin
      bad++;
      $display("FAIL rty_strobes: got strobes=%0d done=%b want 3/1", stbs, done);
    end
    exp = sb_q.pop_front();
    total++;
    if ({status, rd_dat} !== {exp.status, exp.rd}) begin
      bad++;
      $display("FAIL rty_result: got %h/%h want %h/%h", status, rd_dat, exp.status, exp.rd);
    end
  endtask

  task automatic test_err_priority();
    bit ok;
    int n;
    sb_q.push_back('{status: ST_ERR, rd: model_rd});
    press(1'b0, 1'b1, ok);
    serve(0, 3, 8'h77, n);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL err_done: got %b want 1", done); end
    exp = sb_q.pop_front();
    total++;
    if ({status, rd_dat} !== {exp.status, exp.rd}) begin
      bad++;
      $display("FAIL err_result: got %h/%h want %h/%h", status, rd_dat, exp.status, exp.rd);
    end
  endtask

  task automatic test_bounce_and_busy();
    bit ok;
    int n, cnt;
    idle(10);
    btn_wr = 1'b1; idle(2); btn_wr = 1'b0; idle(2);
    btn_wr = 1'b1; idle(3); btn_wr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (wb.cyc_o === 1'b1 || busy === 1'b1) cnt++;
      tick();
    end
    total++;
    if (cnt !== 0) begin bad++; $display("FAIL bounce_filtered: got %0d busy cycles want 0", cnt); end

    sb_q.push_back('{status: ST_OK, rd: 8'h5A});
    model_rd = 8'h5A;
    press(1'b0, 1'b1, ok);
    fork
      serve(25, 0, 8'h5A, n);
      begin
        idle(2);
        sw     = 8'hFF;
        btn_wr = 1'b1;
        idle(10);
        btn_wr = 1'b0;
      end
    join
    total++;
    if ({done, wb.we_o} !== 2'b10 || n !== 26) begin
      bad++;
      $display("FAIL busy_press: got done/we=%b strobes=%0d want 10/26", {done, wb.we_o}, n);
    end
    exp = sb_q.pop_front();
    total++;
    if ({status, rd_dat} !== {exp.status, exp.rd}) begin
      bad++;
      $display("FAIL busy_result: got %h/%h want %h/%h", status, rd_dat, exp.status, exp.rd);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (wb.cyc_o === 1'b1) cnt++;
      tick();
    end
    total++;
    if (cnt !== 0) begin bad++; $display("FAIL busy_press_dropped: got %0d cyc cycles want 0", cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    for (int k = 0; k < 2; k++) begin
      sw = (k == 0) ? 8'h11 : 8'h22;
      sb_q.push_back('{status: ST_OK, rd: model_rd});
      press(1'b1, 1'b0, ok);
      total++;
      if (wb.dat_o !== ((k == 0) ? 8'h11 : 8'h22)) begin
        bad++;
        $display("FAIL b2b_dat%0d: got %h want %h", k, wb.dat_o, (k == 0) ? 8'h11 : 8'h22);
      end
      serve(0, 0, 8'h00, n);
      exp = sb_q.pop_front();
      total++;
      if ({done, status, rd_dat} !== {1'b1, exp.status, exp.rd}) begin
        bad++;
        $display("FAIL b2b_result%0d: got %h want %h", k, {done, status, rd_dat},
                 {1'b1, exp.status, exp.rd});
      end
    end
    // One retry then success: the count must have been cleared by the previous DONE.
    sb_q.push_back('{status: ST_OK, rd: 8'hC3});
    model_rd = 8'hC3;
    press(1'b0, 1'b1, ok);
    serve(0, 2, 8'h00, n);
    tick();
    serve(0, 0, 8'hC3, n);
    exp = sb_q.pop_front();
    total++;
    if ({done, status, rd_dat} !== {1'b1, exp.status, exp.rd}) begin
      bad++;
      $display("FAIL retry_then_ack: got %h want %h", {done, status, rd_dat},
               {1'b1, exp.status, exp.rd});
    end
  endtask

  task automatic test_silent_and_reset();
    bit ok;
    int n;
    press(1'b0, 1'b1, ok);
    n = 0;
    while (wb.cyc_o === 1'b1 && n < 40) begin
      n++;
      tick();
    end
`ifdef WB_CTRL_TIMEOUT_EN
    sb_q.push_back('{status: ST_TIMEOUT, rd: model_rd});
    total++;
    if (n !== 16 || done !== 1'b1) begin
      bad++;
      $display("FAIL timeout_len: got %0d cycles done=%b want 16/1", n, done);
    end
    exp = sb_q.pop_front();
    total++;
    if ({status, rd_dat} !== {exp.status, exp.rd}) begin
      bad++;
      $display("FAIL timeout_result: got %h/%h want %h/%h", status, rd_dat, exp.status, exp.rd);
    end
    press(1'b0, 1'b1, ok);
    tick();
`else
    total++;
    if (n !== 40 || done !== 1'b0 || status === 2'd3) begin
      bad++;
      $display("FAIL wait_forever: got %0d cycles done=%b status=%0d want 40/0/not3",
               n, done, status);
    end
`endif
    total++;
    if ({wb.cyc_o, wb.stb_o} !== 2'b10) begin
      bad++;
      $display("FAIL mid_wait: got cyc/stb=%b want 10", {wb.cyc_o, wb.stb_o});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({wb.cyc_o, wb.stb_o, wb.we_o, wb.dat_o, busy, done, status, rd_dat} !== '0) begin
      bad++;
      $display("FAIL reset_mid_wait: got %h want 0",
               {wb.cyc_o, wb.stb_o, wb.we_o, wb.dat_o, busy, done, status, rd_dat});
    end
    #3;
    rst = 1'b0;
    model_rd = '0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_stall();
    test_retry_exhaust();
    test_err_priority();
    test_bounce_and_busy();
    test_back_to_back();
    test_silent_and_reset();
    total++;
    if (sb_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drained: got %0d entries want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
